dev_bridge_ctrl: RTL and testbench
==================================

DEV_BRIDGE_CTRL -- requirements
Module: dev_bridge_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16, SHALL set the maximum number of BUSY cycles spent waiting for device Ready (legal range 2..255).
REQ-002 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 Req  in  1  M-stage load/store valid this cycle.
REQ-005 We  in  1  1 = store (sw), 0 = load (lw).
REQ-006 Addr  in  32  M-stage data address.
REQ-007 WData  in  32  M-stage store data.
REQ-008 Flush  in  1  exception/eret flush of the M-stage instruction.
REQ-009 HitDev  out  1  combinational decode: Addr lies in a device window.
REQ-010 Dev0_Sel, Dev1_Sel  out  1 each  device strobes.
REQ-011 Dev_Addr  out  32  latched access address.
REQ-012 Dev_WData  out  32  latched store data.
REQ-013 Dev_We  out  1  latched write enable, qualified by the active select.
REQ-014 Dev0_Ready, Dev1_Ready  in  1 each  device completion.
REQ-015 Dev0_RData, Dev1_RData  in  32 each  device read data.
REQ-016 RData  out  32  registered read data returned to the M/W stage.
REQ-017 Stall  out  1  freezes the pipeline at and before the M stage.
REQ-018 BusErr  out  1  one-cycle pulse: device access failed.

Function
REQ-019 Dev0 window SHALL be 0x00007F00..0x00007F0B and Dev1 window 0x00007F10..0x00007F1B, inclusive; HitDev SHALL be 1 only inside these windows.
REQ-020 The FSM SHALL have exactly three states: IDLE, BUSY, DONE.
REQ-021 IDLE->BUSY when Req & HitDev & ~Flush; on that edge Addr, WData, We and the window index SHALL be latched.
REQ-022 In IDLE, Req with HitDev=0, or any Flush, SHALL cause no transition and no device strobe.
REQ-023 In BUSY, exactly one of Dev0_Sel/Dev1_Sel (per latched index) SHALL be 1; Dev_Addr, Dev_WData and Dev_We SHALL hold the latched values.
REQ-024 In BUSY, the selected device's Ready=1 SHALL cause BUSY->DONE; for a load, that device's RData SHALL be registered into RData on the same edge; Ready from the unselected device SHALL be ignored.
REQ-025 Flush asserted while in BUSY SHALL be ignored; the started access SHALL complete.
REQ-026 DONE->IDLE unconditionally after one cycle; RData SHALL hold its value until the next load completes.
REQ-027 Stall SHALL equal (IDLE & Req & HitDev & ~Flush) | BUSY; in DONE, Stall SHALL be 0, so the instruction retires in that cycle.
REQ-028 Minimum access latency SHALL be 2 cycles from request to DONE (Ready asserted in the first BUSY cycle); Stall SHALL be 1 for exactly the request cycle plus each BUSY cycle.
REQ-029 Dev0_Sel, Dev1_Sel and Dev_We SHALL be 0 in IDLE and in DONE.

Reset
REQ-030 reset SHALL force state IDLE, Dev_Addr=0, Dev_WData=0, latched We=0, RData=0, BusErr=0 and the timeout counter=0, with Stall and all selects 0, immediately and independently of clk.
REQ-031 reset asserted during BUSY SHALL abandon the access, with no BusErr and no RData update.

Configuration
REQ-032 With DEV_TIMEOUT_EN defined, an 8-bit counter SHALL clear on entry to BUSY and increment each BUSY cycle; if Ready is still 0 when the count reaches TIMEOUT-1, the FSM SHALL go to DONE, BusErr SHALL be 1 for the DONE cycle, and RData SHALL be loaded with 0 for a load.
REQ-033 Ready arriving in the same cycle as the timeout SHALL win: normal completion, no BusErr.
REQ-034 Without DEV_TIMEOUT_EN, no counter SHALL exist, BUSY SHALL wait indefinitely, and BusErr SHALL be tied to 0.

Verification
REQ-035 Req=1,We=0,Addr=0x7F04, Dev0_Ready=1 in first BUSY cycle with Dev0_RData=0x12345678 -> Stall 1 for 2 cycles, Dev0_Sel for 1 cycle, RData=0x12345678 in DONE.
REQ-036 Req=1,We=1,Addr=0x7F10,WData=0xA5A5A5A5, Dev1_Ready after 3 cycles -> Dev1_Sel & Dev_We high for 3 BUSY cycles, Dev_WData=0xA5A5A5A5, Dev0_Sel never 1.
REQ-037 Req=1,Addr=0x7F0C (gap) and Addr=0x3000 -> HitDev=0, Stall=0, no select.
REQ-038 Req=1,Addr=0x7F00 with Flush=1 -> stays IDLE; Flush pulsed mid-BUSY -> access completes normally.
REQ-039 DEV_TIMEOUT_EN, TIMEOUT=16, Dev0_Ready held 0 -> DONE after 16 BUSY cycles, BusErr 1-cycle pulse, RData=0; same run with Ready on the 16th BUSY cycle -> BusErr=0.
REQ-040 reset asserted asynchronously mid-BUSY -> Stall, selects and BusErr drop to 0 before the next clk edge; state IDLE.

Source files
------------

// File: rtl/dev_bridge_ctrl.sv
// rtl/dev_bridge_ctrl.sv - M-stage load/store bridge to two memory-mapped devices
//
// Purpose: decodes the M-stage data address against two device windows,
// latches the access, strobes the selected device until it reports Ready,
// stalls the pipeline meanwhile and returns registered read data.
//
// Optional feature macro: DEV_TIMEOUT_EN (BUSY timeout with BusErr pulse).
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   Req, We, Addr, WData       M-stage access request (We=1 store)
//   Flush                      kills the M-stage request while IDLE
//   HitDev                     combinational window decode of Addr
//   Dev0_Sel, Dev1_Sel         device strobes (BUSY only)
//   Dev_Addr, Dev_WData        latched address / store data
//   Dev_We                     latched write enable, qualified by BUSY
//   Dev0_Ready, Dev1_Ready     device completion
//   Dev0_RData, Dev1_RData     device read data
//   RData                      registered load data
//   Stall                      pipeline freeze at and before M
//   BusErr                     one-cycle access-failure pulse (DONE)

module dev_bridge_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic        We,
    input  logic [31:0] Addr,
    input  logic [31:0] WData,
    input  logic        Flush,
    output logic        HitDev,
    output logic        Dev0_Sel,
    output logic        Dev1_Sel,
    output logic [31:0] Dev_Addr,
    output logic [31:0] Dev_WData,
    output logic        Dev_We,
    input  logic        Dev0_Ready,
    input  logic        Dev1_Ready,
    input  logic [31:0] Dev0_RData,
    input  logic [31:0] Dev1_RData,
    output logic [31:0] RData,
    output logic        Stall,
    output logic        BusErr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic        idx_q, idx_d;
    logic [31:0] rdata_q, rdata_d;

    logic        hit0, hit1;
    logic        start;
    logic        busy;
    logic        ready_sel;
    logic [31:0] rdata_sel;

    // Each window is 12 bytes (three words) at the bottom of a 16-byte slot.
    assign hit0   = (Addr[31:4] == 28'h00007F0) && (Addr[3:0] <= 4'hB);
    assign hit1   = (Addr[31:4] == 28'h00007F1) && (Addr[3:0] <= 4'hB);
    assign HitDev = hit0 | hit1;

    assign start = (state_q == IDLE) && Req && HitDev && !Flush;
    assign busy  = (state_q == BUSY);

    // Only the latched device is listened to; the other one's Ready is ignored.
    assign ready_sel = idx_q ? Dev1_Ready : Dev0_Ready;
    assign rdata_sel = idx_q ? Dev1_RData : Dev0_RData;

`ifdef DEV_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       buserr_q, buserr_d;
`else
    logic       unused_tmo;
    assign unused_tmo = ^TMO_LAST;
`endif

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        idx_d    = idx_q;
        rdata_d  = rdata_q;
`ifdef DEV_TIMEOUT_EN
        cnt_d    = cnt_q;
        buserr_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = BUSY;
                    addr_d  = Addr;
                    wdata_d = WData;
                    we_d    = We;
                    idx_d   = hit1;
`ifdef DEV_TIMEOUT_EN
                    cnt_d   = 8'd0;
`endif
                end
            end
            BUSY: begin
                // Flush is deliberately not looked at here: a started device
                // access always runs to completion.
                if (ready_sel) begin
                    state_d = DONE;
                    if (!we_q) begin
                        rdata_d = rdata_sel;
                    end
`ifdef DEV_TIMEOUT_EN
                end else if (cnt_q == TMO_LAST) begin
                    state_d  = DONE;
                    buserr_d = 1'b1;
                    if (!we_q) begin
                        rdata_d = 32'd0;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            we_q     <= 1'b0;
            idx_q    <= 1'b0;
            rdata_q  <= 32'd0;
`ifdef DEV_TIMEOUT_EN
            cnt_q    <= 8'd0;
            buserr_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            idx_q    <= idx_d;
            rdata_q  <= rdata_d;
`ifdef DEV_TIMEOUT_EN
            cnt_q    <= cnt_d;
            buserr_q <= buserr_d;
`endif
        end
    end

    assign Dev0_Sel  = busy && !idx_q;
    assign Dev1_Sel  = busy && idx_q;
    assign Dev_Addr  = addr_q;
    assign Dev_WData = wdata_q;
    assign Dev_We    = busy && we_q;
    assign RData     = rdata_q;
    assign Stall     = start || busy;

`ifdef DEV_TIMEOUT_EN
    assign BusErr = buserr_q;
`else
    assign BusErr = 1'b0;
`endif

endmodule

// File: tb/tb_dev_bridge_ctrl.sv
// tb/tb_dev_bridge_ctrl.sv - scoreboard bench for dev_bridge_ctrl

module tb_dev_bridge_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        Req, We, Flush;
    logic [31:0] Addr, WData;
    logic        HitDev, Dev0_Sel, Dev1_Sel, Dev_We;
    logic [31:0] Dev_Addr, Dev_WData;
    logic        Dev0_Ready, Dev1_Ready;
    logic [31:0] Dev0_RData, Dev1_RData;
    logic [31:0] RData;
    logic        Stall, BusErr;

    dev_bridge_ctrl #(.TIMEOUT(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .Req        (Req),
        .We         (We),
        .Addr       (Addr),
        .WData      (WData),
        .Flush      (Flush),
        .HitDev     (HitDev),
        .Dev0_Sel   (Dev0_Sel),
        .Dev1_Sel   (Dev1_Sel),
        .Dev_Addr   (Dev_Addr),
        .Dev_WData  (Dev_WData),
        .Dev_We     (Dev_We),
        .Dev0_Ready (Dev0_Ready),
        .Dev1_Ready (Dev1_Ready),
        .Dev0_RData (Dev0_RData),
        .Dev1_RData (Dev1_RData),
        .RData      (RData),
        .Stall      (Stall),
        .BusErr     (BusErr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        buserr;
        int          busy;
    } exp_t;

    exp_t        sb[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] model_rdata = 32'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One device access; ready_at = BUSY cycle in which the selected device
    // answers (0 = never). The unselected device always claims Ready.
    task automatic do_access(input string name, input logic we, input logic [31:0] addr,
                             input logic [31:0] wd, input logic dev, input int ready_at,
                             input logic [31:0] rd, input bit flush_mid,
                             input int exp_busy, input bit exp_err);
        exp_t e;
        int   nbusy;
        bit   done;
        if (!we) model_rdata = exp_err ? 32'd0 : rd;
        e.rdata  = model_rdata;
        e.buserr = exp_err;
        e.busy   = exp_busy;
        sb.push_back(e);

        @(negedge clk);
        Req = 1'b1; We = we; Addr = addr; WData = wd; Flush = 1'b0;
        #1;
        check({name, "_req_hit"}, 32'(HitDev), 32'd1);
        check({name, "_req_stall"}, 32'(Stall), 32'd1);
        check({name, "_req_nosel"}, 32'({Dev0_Sel, Dev1_Sel}), 32'd0);

        nbusy = 0;
        done  = 0;
        for (int k = 1; k <= 300 && !done; k++) begin
            @(negedge clk);
            if (!Stall) begin
                done = 1;
            end else begin
                nbusy++;
                if (k == 1 || k == ready_at) begin
                    check({name, "_sel0"}, 32'(Dev0_Sel), 32'(!dev));
                    check({name, "_sel1"}, 32'(Dev1_Sel), 32'(dev));
                    check({name, "_we"}, 32'(Dev_We), 32'(we));
                    check({name, "_addr"}, Dev_Addr, addr);
                    check({name, "_wdata"}, Dev_WData, wd);
                end
                Addr  = 32'h0000_3000;
                WData = ~wd;
                Flush = flush_mid && (k == 1);
                if (dev) begin
                    Dev1_Ready = (k == ready_at); Dev0_Ready = 1'b1;
                    Dev1_RData = rd;              Dev0_RData = ~rd;
                end else begin
                    Dev0_Ready = (k == ready_at); Dev1_Ready = 1'b1;
                    Dev0_RData = rd;              Dev1_RData = ~rd;
                end
            end
        end
        if (!done) check({name, "_done_bound"}, 32'd0, 32'd1);

        // DONE cycle: retire, compare against the scoreboard.
        e = sb.pop_front();
        check({name, "_done_stall"}, 32'(Stall), 32'd0);
        check({name, "_done_nosel"}, 32'({Dev0_Sel, Dev1_Sel, Dev_We}), 32'd0);
        check({name, "_busy_cycles"}, 32'(nbusy), 32'(e.busy));
        check({name, "_rdata"}, RData, e.rdata);
        check({name, "_buserr"}, 32'(BusErr), 32'(e.buserr));
        Req = 1'b0; Flush = 1'b0; Dev0_Ready = 1'b0; Dev1_Ready = 1'b0;
        @(negedge clk);
        check({name, "_idle_buserr"}, 32'(BusErr), 32'd0);
        check({name, "_rdata_hold"}, RData, e.rdata);
    endtask

    initial begin
        reset = 1'b1; Req = 1'b0; We = 1'b0; Flush = 1'b0;
        Addr = 32'd0; WData = 32'd0;
        Dev0_Ready = 1'b0; Dev1_Ready = 1'b0;
        Dev0_RData = 32'd0; Dev1_RData = 32'd0;

        #3;
        check("rst_stall", 32'(Stall), 32'd0);
        check("rst_sel", 32'({Dev0_Sel, Dev1_Sel, Dev_We}), 32'd0);
        check("rst_rdata", RData, 32'd0);
        check("rst_buserr", 32'(BusErr), 32'd0);
        check("rst_addr", Dev_Addr, 32'd0);
        check("rst_wdata", Dev_WData, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Minimum-latency load from device 0.
        do_access("ld0", 1'b0, 32'h0000_7F04, 32'h0, 1'b0, 1, 32'h1234_5678, 1'b0, 1, 1'b0);
        // Store to device 1, answered in the third BUSY cycle.
        do_access("st1", 1'b1, 32'h0000_7F10, 32'hA5A5_A5A5, 1'b1, 3, 32'hDEAD_0001, 1'b0, 3, 1'b0);

        // Window boundaries and holes: no request started.
        Req = 1'b1; We = 1'b0;
        Addr = 32'h0000_7F0C; #1;
        check("gap_hit", 32'(HitDev), 32'd0);
        check("gap_stall", 32'(Stall), 32'd0);
        Addr = 32'h0000_3000; #1;
        check("far_hit", 32'(HitDev), 32'd0);
        check("far_stall", 32'(Stall), 32'd0);
        @(negedge clk);
        check("miss_nosel", 32'({Dev0_Sel, Dev1_Sel, Stall}), 32'd0);
        Req = 1'b0;
        Addr = 32'h0000_7F0B; #1; check("edge0_hi", 32'(HitDev), 32'd1);
        Addr = 32'h0000_7F1B; #1; check("edge1_hi", 32'(HitDev), 32'd1);
        Addr = 32'h0000_7F1C; #1; check("edge1_out", 32'(HitDev), 32'd0);
        Addr = 32'h0000_7EFF; #1; check("edge0_out", 32'(HitDev), 32'd0);

        // Flushed request in IDLE does nothing.
        @(negedge clk);
        Req = 1'b1; Addr = 32'h0000_7F00; Flush = 1'b1; #1;
        check("flush_stall", 32'(Stall), 32'd0);
        @(negedge clk);
        check("flush_idle", 32'({Dev0_Sel, Dev1_Sel, Stall}), 32'd0);
        Req = 1'b0; Flush = 1'b0;

        // Flush mid-BUSY is ignored.
        do_access("flmid", 1'b0, 32'h0000_7F18, 32'h0, 1'b1, 2, 32'hCAFE_F00D, 1'b1, 2, 1'b0);

`ifdef DEV_TIMEOUT_EN
        do_access("tmo", 1'b0, 32'h0000_7F08, 32'h0, 1'b0, 0, 32'h5555_AAAA, 1'b0, 16, 1'b1);
        do_access("tmo_rdy", 1'b0, 32'h0000_7F08, 32'h0, 1'b0, 16, 32'h0BAD_BEEF, 1'b0, 16, 1'b0);
`else
        do_access("longwait", 1'b0, 32'h0000_7F08, 32'h0, 1'b0, 40, 32'h0BAD_BEEF, 1'b0, 40, 1'b0);
`endif

        // Asynchronous reset in the middle of an access.
        @(negedge clk);
        Req = 1'b1; We = 1'b0; Addr = 32'h0000_7F08;
        @(negedge clk);
        @(negedge clk);
        Req = 1'b0;
        check("prerst_sel", 32'(Dev0_Sel), 32'd1);
        check("prerst_rdata", RData, model_rdata);
        #1 reset = 1'b1;
        #1;
        check("arst_stall", 32'(Stall), 32'd0);
        check("arst_sel", 32'({Dev0_Sel, Dev1_Sel, Dev_We}), 32'd0);
        check("arst_buserr", 32'(BusErr), 32'd0);
        check("arst_rdata", RData, 32'd0);
        check("arst_addr", Dev_Addr, 32'd0);
        model_rdata = 32'd0;
        @(negedge clk);
        reset = 1'b0;

        do_access("post", 1'b0, 32'h0000_7F14, 32'h0, 1'b1, 1, 32'h600D_CAFE, 1'b0, 1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
